// File: rtl/controlador_multiciclo.sv
// Multicycle sequencing controller: step counter, 9-bit instruction register and control decoder in one FSM.
// Optional feature: define MVNZ_EN to decode opcode 100 as mvnz (conditional move on GNZ).
module controlador_multiciclo (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [8:0] Instrucao,
    input  logic       Run,
    input  logic       GNZ,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done,
    output logic [1:0] Tstep
);

    localparam int unsigned IR_W  = 9;
    localparam int unsigned REG_N = 8;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } tstep_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

    tstep_t            state_q;
    tstep_t            state_d;
    logic [IR_W-1:0]   ir_q;
    logic [2:0]        opcode;
    logic [2:0]        rx;
    logic [2:0]        ry;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

`ifndef MVNZ_EN
    logic unused_gnz;
    assign unused_gnz = GNZ;
`endif

    // Register index 0 (R0) maps to the MSB of the one-hot enable vectors.
    function automatic logic [REG_N-1:0] reg_sel(input logic [2:0] idx);
        return REG_N'(8'h80 >> idx);
    endfunction

    // State and instruction register; IR only loads on a T0 fetch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T0 && Run) begin
                ir_q <= Instrucao;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        IRin    = 1'b0;
        Rin     = '0;
        Rout    = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        DINout  = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        Tstep   = state_q;

        case (state_q)
            T0: begin
                IRin = Run;
                if (Run) begin
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout    = reg_sel(ry);
                        Rin     = reg_sel(rx);
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        Rin     = reg_sel(rx);
                        Done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout    = reg_sel(rx);
                        Ain     = 1'b1;
                        state_d = T2;
                    end
`ifdef MVNZ_EN
                    OP_MVNZ: begin
                        if (GNZ) begin
                            Rout = reg_sel(ry);
                            Rin  = reg_sel(rx);
                        end
                        Done    = 1'b1;
                        state_d = T0;
                    end
`endif
                    default: begin
                        Done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                Rout    = reg_sel(ry);
                Gin     = 1'b1;
                AddSub  = opcode[0];
                state_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = reg_sel(rx);
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

endmodule

// File: doc/controlador_multiciclo.md
# controlador_multiciclo

Self-contained sequencing controller for the 16-bit multiciclo datapath (R0–R7, A, G, add/sub ALU, bus mux). It merges the step counter, the 9-bit instruction register and the control decoder into one FSM. Each cycle it drives the register enables, the bus-mux selects and the ALU mode. Instructions are accepted on a Run/Done handshake, and the block sits between the DIN source and the datapath registers.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Instrucao  in  9  instruction word, taken from DIN[8:0]. Format III XXX YYY: opcode, destination Rx, source Ry.
- Run  in  1  start request, sampled only in T0.
- GNZ  in  1  G register non-zero flag. Used only when MVNZ_EN is defined; otherwise ignored.
- IRin  out  1  instruction-register load strobe (also loads the external IR copy).
- Rin  out  8  register write enables, one-hot. Bit 7 = R0 … bit 0 = R7.
- Rout  out  8  bus source select for the registers, one-hot, same bit order as Rin.
- Ain  out  1  A register load.
- Gin  out  1  G register load.
- Gout  out  1  G drives the bus.
- DINout  out  1  DIN drives the bus.
- AddSub  out  1  ALU mode: 0 = A+bus, 1 = A−bus.
- Done  out  1  last cycle of the instruction.
- Tstep  out  2  current step: 00 = T0, 01 = T1, 10 = T2, 11 = T3.

## Operation
- State register Tstep holds T0–T3. Internal register IR is 9 bits.
- All outputs are combinational from (Tstep, IR, Run, GNZ).
- At most one of Rout/Gout/DINout is active in any cycle.
- T0 (idle/fetch):
  - IRin = Run.
  - On a clock edge with Run=1: IR ← Instrucao, go to T1.
  - With Run=0: stay in T0.
- Opcode 000 mv: T1 drives Rout[Ry] and Rin[Rx] with Done=1, then T0.
- Opcode 001 mvi: T1 drives DINout and Rin[Rx] with Done=1, then T0. The immediate is whatever DIN holds during T1.
- Opcode 010 add and 011 sub:
  - T1: Rout[Rx], Ain.
  - T2: Rout[Ry], Gin, AddSub = opcode[0].
  - T3: Gout, Rin[Rx], Done.
  - Then T0.
- Other opcodes: T1 asserts Done=1 with no other enables (NOP), then T0.
- Run is ignored outside T0. Instrucao is ignored except on a T0 edge with Run=1.
- Register index mapping: Rx=000 selects bit 7 (R0); Rx=111 selects bit 0 (R7).
- mv with Rx=Ry is legal: a single register has both Rout and Rin active.

## Timing
- Reset (asynchronous, Resetn=0):
  - Tstep=T0 and IR=0 immediately, without waiting for a clock edge.
  - All outputs go to 0 except IRin, which follows Run.
- Reset mid-instruction aborts it: no further Rin/Gin/Ain pulses, and Done is not asserted.
- Latency from the Run-sampling edge to the Done cycle: mv/mvi/NOP = 1 cycle (T1); add/sub = 3 cycles (T3).
- Done is high for exactly one cycle. The next cycle is T0.
- Back-to-back instructions: if Run is high in the T0 following Done, the next instruction is fetched at that edge. Throughput is 2 cycles for mv and 4 cycles for add.
- The Tstep counter never wraps from T3 to T0 except through Done; T3 always returns to T0.

## Configuration
- MVNZ_EN defined:
  - Opcode 100 is mvnz. T1 asserts Done.
  - If GNZ=1, T1 also drives Rout[Ry] and Rin[Rx]. If GNZ=0, no enables are driven.
  - GNZ is sampled combinationally during T1.
- MVNZ_EN undefined: opcode 100 behaves as a NOP and GNZ is unused.

## Test plan
- Reset: Resetn=0 asserted mid-T2 of an add. Required: Tstep=00 with no clock edge; Ain/Gin/Rin/Done all 0; after release, idle until Run.
- mvi: Run=1, Instrucao=001_000_000, then DIN=0x0005 during T1. Required: T1 shows DINout=1, Rin=8'b1000_0000, Done=1; next cycle Tstep=00.
- mv: Instrucao=000_001_000. Required: T1 shows Rout=8'b1000_0000, Rin=8'b0100_0000, Done=1.
- add then sub back-to-back, Run held high: add 010_000_001 followed by sub 011_000_001.
  - add, per step: T1 Rout=0x80 with Ain; T2 Rout=0x40 with Gin, AddSub=0; T3 Gout with Rin=0x80, Done.
  - sub: same sequence with AddSub=1 in T2.
  - The second IRin pulse occurs in the T0 immediately after the add's Done.
- Run ignored outside T0: toggle Run during T1–T3 of an add. Required: IRin stays 0; sequence unchanged.
- mvnz (MVNZ_EN defined), Instrucao=100_010_011:
  - GNZ=1: Rout=0x10, Rin=0x20, Done=1.
  - GNZ=0: only Done=1.
  - With MVNZ_EN undefined: only Done=1.
